lfo_multi: RTL and testbench

Multi-channel, parametrised low-frequency oscillator for the modulation section of the synth. Replaces the single-channel LFO. Adds:
- N independent channels, time-multiplexed over one shared arithmetic datapath.
- Generic output and phase widths.
- Per-channel phase retrigger (sync).
- A fifth waveform: random sample-and-hold.

Each channel advances once per audio sample strobe. Its registered output feeds the DAC/modulation routing.

---
 rtl/lfo_multi.sv | 186 ++++++++++++++++++
 tb/tb_lfo_multi.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfo_multi.sv
// lfo_multi: multi-channel low-frequency oscillator for the modulation section.
//
// CHANNELS phase accumulators share one arithmetic datapath. Each accepted
// sample_en starts a frame that visits one channel per clock, updates its
// phase and output register, and finishes with a one-clock d_valid pulse.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   reset_n      synchronous active-low reset
//   sample_en    audio-rate strobe, starts a frame when idle
//   wave_type    3 bits per channel: square/triangle/saw/sine/random S&H
//   frequency_in FREQ_W bits per channel, phase increment per frame
//   pulse_width  OUT_W bits per channel, square threshold
//   retrig       per-channel phase reset request, latched until its slot
//   d_out        OUT_W bits per channel, registered waveform value
//   wrap         per-channel one-clock accumulator overflow pulse
//   d_valid      one-clock pulse after a complete frame
//   busy         high while a frame is in progress
module lfo_multi #(
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 10,
  parameter int FREQ_W   = 10,
  parameter int PHASE_W  = 24
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_en,
  input  logic [3*CHANNELS-1:0]        wave_type,
  input  logic [FREQ_W*CHANNELS-1:0]   frequency_in,
  input  logic [OUT_W*CHANNELS-1:0]    pulse_width,
  input  logic [CHANNELS-1:0]          retrig,
  output logic [OUT_W*CHANNELS-1:0]    d_out,
  output logic [CHANNELS-1:0]          wrap,
  output logic                         d_valid,
  output logic                         busy
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = 4 * OUT_W + 2;  // holds t*t*(3N-2t) without overflow
  localparam logic [SW-1:0] THREE_N = SW'(3) << OUT_W;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       ch_reg, ch_next;
  logic [15:0]         lfsr_reg;
  logic                d_valid_reg;
  logic [PHASE_W-1:0]  phase_reg [CHANNELS];
  logic [OUT_W-1:0]    dout_reg  [CHANNELS];
  logic [CHANNELS-1:0] pend_reg;
  logic [CHANNELS-1:0] wrap_reg;

  logic start;
  logic slot_active;
  assign start       = (state_reg == IDLE) && sample_en;
  assign slot_active = (state_reg == UPDATE);

  // Shared datapath: select the channel whose slot this is.
  logic [FREQ_W-1:0]  sel_freq;
  logic [OUT_W-1:0]   sel_pw;
  logic [2:0]         sel_wave;
  logic [PHASE_W-1:0] sel_phase;
  logic [OUT_W-1:0]   sel_dout;
  logic               sel_eff;

  assign sel_freq  = frequency_in[ch_reg*FREQ_W +: FREQ_W];
  assign sel_pw    = pulse_width[ch_reg*OUT_W +: OUT_W];
  assign sel_wave  = wave_type[ch_reg*3 +: 3];
  assign sel_phase = phase_reg[ch_reg];
  assign sel_dout  = dout_reg[ch_reg];
  assign sel_eff   = pend_reg[ch_reg] | retrig[ch_reg];

  logic [PHASE_W:0]   sum;
  logic [PHASE_W-1:0] new_phase;
  logic               carry;
  logic [OUT_W-1:0]   tap;

  assign sum       = {1'b0, sel_phase} + {{(PHASE_W+1-FREQ_W){1'b0}}, sel_freq};
  assign new_phase = sel_eff ? '0 : sum[PHASE_W-1:0];
  assign carry     = ~sel_eff & sum[PHASE_W];
  assign tap       = new_phase[PHASE_W-1 -: OUT_W];

  // Triangle: doubled tap, mirrored in the upper half (M - x == ~x).
  logic [OUT_W-1:0] tap2;
  logic [OUT_W-1:0] tri_val;
  assign tap2    = {tap[OUT_W-2:0], 1'b0};
  assign tri_val = tap[OUT_W-1] ? ~tap2 : tap2;

  // Sine: smoothstep of the triangle, t^2 (3N - 2t) / N^2.
  logic [SW-1:0]    t_ext, prod, prod_sh;
  logic [OUT_W-1:0] sine_val;
  assign t_ext    = SW'(tri_val);
  assign prod     = t_ext * t_ext * (THREE_N - (t_ext << 1));
  assign prod_sh  = prod >> (2 * OUT_W);
  assign sine_val = (|prod_sh[SW-1:OUT_W]) ? '1 : prod_sh[OUT_W-1:0];

  logic [OUT_W-1:0] wave_val;
  always_comb begin
    wave_val = '0;
    case (sel_wave)
      3'b000:  wave_val = (tap < sel_pw) ? '1 : '0;
      3'b001:  wave_val = tri_val;
      3'b010:  wave_val = tap;
      3'b011:  wave_val = sine_val;
      3'b100:  wave_val = (carry | sel_eff) ? lfsr_reg[15 -: OUT_W] : sel_dout;
      default: wave_val = '0;
    endcase
  end

  // Frame sequencer.
  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    case (state_reg)
      IDLE: begin
        if (sample_en) begin
          state_next = UPDATE;
          ch_next    = '0;
        end
      end
      UPDATE: begin
        if (ch_reg == LAST_CH) begin
          state_next = DONE;
        end else begin
          ch_next = CW'(ch_reg + 1'b1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic lfsr_fb;
  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      ch_reg      <= '0;
      lfsr_reg    <= 16'hACE1;
      d_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ch_reg      <= ch_next;
      d_valid_reg <= (state_reg == DONE);
      if (start) begin
        lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
      end
    end
  end

  // Per-channel state: written only in its own slot; a retrig outside the
  // slot is held in pend until the slot consumes it.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        phase_reg[gi] <= '0;
        dout_reg[gi]  <= '0;
        pend_reg[gi]  <= 1'b0;
        wrap_reg[gi]  <= 1'b0;
      end else begin
        wrap_reg[gi] <= 1'b0;
        if (slot_active && (ch_reg == CW'(gi))) begin
          phase_reg[gi] <= new_phase;
          dout_reg[gi]  <= wave_val;
          pend_reg[gi]  <= 1'b0;
          wrap_reg[gi]  <= carry;
        end else if (retrig[gi]) begin
          pend_reg[gi] <= 1'b1;
        end
      end
    end

    assign d_out[gi*OUT_W +: OUT_W] = dout_reg[gi];
    assign wrap[gi]                 = wrap_reg[gi];
  end

  assign d_valid = d_valid_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_lfo_multi.sv
// tb_lfo_multi: randomized self-checking bench for lfo_multi (2 channels,
// 10-bit outputs, 12-bit phase). A behavioural model computes expected
// outputs from the waveform formulas; each test task compares inline.
module tb_lfo_multi;

  localparam int C  = 2;
  localparam int OW = 10;
  localparam int FW = 10;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sample_en = 1'b0;
  logic [3*C-1:0]  wave_type = '0;
  logic [FW*C-1:0] frequency_in = '0;
  logic [OW*C-1:0] pulse_width = '0;
  logic [C-1:0]    retrig = '0;
  logic [OW*C-1:0] d_out;
  logic [C-1:0]    wrap;
  logic            d_valid;
  logic            busy;

  always #5 clk = ~clk;

  lfo_multi #(.CHANNELS(C), .OUT_W(OW), .FREQ_W(FW), .PHASE_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en),
    .wave_type(wave_type), .frequency_in(frequency_in),
    .pulse_width(pulse_width), .retrig(retrig),
    .d_out(d_out), .wrap(wrap), .d_valid(d_valid), .busy(busy)
  );

  int n_run = 0;
  int n_fail = 0;
  int frame_no = 0;

  // Configuration held for a whole frame.
  int wt_v[2], fq_v[2], pw_v[2];
  logic [1:0] rt_c[6];
  bit se_extra = 1'b0;

  // Reference model state.
  int ph_m[2], pend_m[2], dout_m[2], lfsr_m, exp_d[2], exp_w[2];

  // Observations per frame cycle (0 = sample_en cycle).
  logic [OW*C-1:0] obs_dt[6];
  logic [1:0]      obs_wv[6];
  logic            obs_dv[6], obs_bz[6];
  int              obs_d[2];
  int              prev_d1;

  function automatic int wave_calc(input int wt, input int p, input int pw,
                                   input int eff, input int carry,
                                   input int old, input int lf);
    int t;
    longint s;
    t = (p < 512) ? (2 * p) % 1024 : 1023 - ((2 * p) % 1024);
    case (wt)
      0: return (p < pw) ? 1023 : 0;
      1: return t;
      2: return p;
      3: begin
        s = (longint'(t) * t * (3072 - 2 * t)) >> 20;
        return (s > 1023) ? 1023 : int'(s);
      end
      4: return (carry != 0 || eff != 0) ? ((lf >> 6) & 1023) : old;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph_m[k] = 0; pend_m[k] = 0; dout_m[k] = 0;
    end
    lfsr_m = 16'hACE1;
  endtask

  task automatic model_frame();
    int fb, sum, carry, eff, p;
    fb = ((lfsr_m >> 15) ^ (lfsr_m >> 13) ^ (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 1;
    lfsr_m = ((lfsr_m << 1) | fb) & 16'hFFFF;
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (c == k + 1) begin
          eff = pend_m[k] | int'(rt_c[c][k]);
          pend_m[k] = 0;
          if (eff != 0) begin
            ph_m[k] = 0; carry = 0;
          end else begin
            sum = ph_m[k] + fq_v[k];
            carry = sum / 4096;
            ph_m[k] = sum % 4096;
          end
          p = ph_m[k] / 4;
          dout_m[k] = wave_calc(wt_v[k], p, pw_v[k], eff, carry, dout_m[k], lfsr_m);
          exp_d[k] = dout_m[k];
          exp_w[k] = carry;
        end else if (rt_c[c][k]) begin
          pend_m[k] = 1;
        end
      end
    end
  endtask

  task automatic apply_cfg();
    wave_type    = {3'(wt_v[1]), 3'(wt_v[0])};
    frequency_in = {10'(fq_v[1]), 10'(fq_v[0])};
    pulse_width  = {10'(pw_v[1]), 10'(pw_v[0])};
  endtask

  // Drives one frame and records outputs; it makes no comparisons itself.
  task automatic run_frame();
    rt_c[5] = 2'b00;
    prev_d1 = dout_m[1];
    model_frame();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      obs_dt[c] = d_out; obs_wv[c] = wrap; obs_dv[c] = d_valid; obs_bz[c] = busy;
      if (c == 0) apply_cfg();
      sample_en = (c == 0) || (se_extra && c >= 1 && c <= 3);
      retrig    = rt_c[c];
    end
    obs_d[0] = int'(obs_dt[2][9:0]);
    obs_d[1] = int'(obs_dt[3][19:10]);
    frame_no++;
    $display("[TB] frame %0d wave=%0d/%0d freq=%0d/%0d d_out=%0d/%0d wrap=%b/%b d_valid=%b",
             frame_no, wt_v[0], wt_v[1], fq_v[0], fq_v[1], obs_d[0], obs_d[1],
             obs_wv[2][0], obs_wv[3][1], obs_dv[4]);
  endtask

  task automatic clear_rt();
    for (int c = 0; c < 6; c++) rt_c[c] = 2'b00;
  endtask

  task automatic idle_retrig(input logic [1:0] mask);
    @(negedge clk);
    retrig = mask;
    for (int k = 0; k < 2; k++) if (mask[k]) pend_m[k] = 1;
    @(negedge clk);
    retrig = 2'b00;
  endtask

  // Retrigger channel ch to phase 0, then step it to the requested tap.
  task automatic set_tap(input int ch, input int tap);
    int rem, f;
    clear_rt();
    rt_c[0][ch] = 1'b1;
    fq_v[ch] = 0;
    fq_v[1-ch] = $urandom_range(0, 1023);
    run_frame();
    clear_rt();
    rem = tap * 4;
    while (rem > 0) begin
      f = (rem > 1020) ? 1020 : rem;
      fq_v[ch] = f;
      fq_v[1-ch] = $urandom_range(0, 1023);
      run_frame();
      rem -= f;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sample_en = 1'($urandom); retrig = 2'($urandom);
    wave_type = 6'($urandom); frequency_in = 20'($urandom); pulse_width = 20'($urandom);
    @(negedge clk);
    @(negedge clk);
    n_run++; if (d_out !== '0) begin n_fail++; $display("FAIL reset_d_out got %0h want 0", d_out); end
    n_run++; if (wrap !== '0) begin n_fail++; $display("FAIL reset_wrap got %b want 00", wrap); end
    n_run++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d_valid got %b want 0", d_valid); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    reset_n = 1'b1; sample_en = 1'b0; retrig = 2'b00;
    model_reset();
    clear_rt();
  endtask

  task automatic test_saw();
    logic [1:0] ew;
    wt_v[0] = 2; fq_v[0] = 4; pw_v[0] = 0;
    wt_v[1] = 4;
    for (int n = 1; n <= 1025; n++) begin
      fq_v[1] = $urandom_range(0, 1023);
      pw_v[1] = $urandom_range(0, 1023);
      run_frame();
      ew = {1'b0, 1'((n % 1024) == 0)};
      n_run++; if (obs_d[0] !== n % 1024) begin n_fail++; $display("FAIL saw_d_out frame %0d got %0d want %0d", n, obs_d[0], n % 1024); end
      n_run++; if (obs_wv[2] !== ew || obs_wv[4] !== 2'b00) begin n_fail++; $display("FAIL saw_wrap0 frame %0d got %b want %b", n, obs_wv[2], ew); end
      n_run++; if (obs_d[1] !== exp_d[1]) begin n_fail++; $display("FAIL rand_ch1 frame %0d got %0d want %0d", n, obs_d[1], exp_d[1]); end
      n_run++; if (obs_wv[3] !== {1'(exp_w[1]), 1'b0}) begin n_fail++; $display("FAIL wrap1 frame %0d got %b want %b", n, obs_wv[3], {1'(exp_w[1]), 1'b0}); end
      n_run++; if (int'(obs_dt[2][19:10]) !== prev_d1) begin n_fail++; $display("FAIL hold_ch1 frame %0d got %0d want %0d", n, obs_dt[2][19:10], prev_d1); end
      n_run++; if (obs_dv[3] !== 1'b0 || obs_dv[4] !== 1'b1 || obs_dv[5] !== 1'b0) begin n_fail++; $display("FAIL d_valid_timing frame %0d got %b%b%b want 010", n, obs_dv[3], obs_dv[4], obs_dv[5]); end
      n_run++; if (obs_bz[1] !== 1'b1 || obs_bz[2] !== 1'b1 || obs_bz[4] !== 1'b0) begin n_fail++; $display("FAIL busy frame %0d got %b%b%b want 110", n, obs_bz[1], obs_bz[2], obs_bz[4]); end
    end
  endtask

  task automatic test_square();
    int taps[4] = '{799, 800, 0, 1023};
    int want[4] = '{1023, 0, 1023, 0};
    wt_v[0] = 0; pw_v[0] = 800; wt_v[1] = 2;
    for (int i = 0; i < 4; i++) begin
      set_tap(0, taps[i]);
      n_run++; if (obs_d[0] !== want[i]) begin n_fail++; $display("FAIL square_tap%0d got %0d want %0d", taps[i], obs_d[0], want[i]); end
    end
    for (int i = 0; i < 20; i++) begin
      fq_v[0] = $urandom_range(0, 1023); fq_v[1] = $urandom_range(0, 1023);
      run_frame();
      n_run++; if (obs_d[0] !== exp_d[0]) begin n_fail++; $display("FAIL square_rand got %0d want %0d", obs_d[0], exp_d[0]); end
    end
    pw_v[0] = 0;
    set_tap(0, 0);
    n_run++; if (obs_d[0] !== 0) begin n_fail++; $display("FAIL square_pw0 got %0d want 0", obs_d[0]); end
  endtask

  task automatic test_tri_sine();
    int taps[5] = '{0, 256, 511, 512, 1023};
    int tri_w[5] = '{0, 512, 1022, 1023, 1};
    int sin_w[5] = '{0, 512, 1023, 1023, 0};
    wt_v[0] = 3; wt_v[1] = 1;
    for (int i = 0; i < 5; i++) begin
      set_tap(1, taps[i]);
      n_run++; if (obs_d[1] !== tri_w[i]) begin n_fail++; $display("FAIL tri_tap%0d got %0d want %0d", taps[i], obs_d[1], tri_w[i]); end
      set_tap(0, taps[i]);
      n_run++; if (obs_d[0] !== sin_w[i]) begin n_fail++; $display("FAIL sine_tap%0d got %0d want %0d", taps[i], obs_d[0], sin_w[i]); end
    end
  endtask

  task automatic test_retrig();
    wt_v[0] = 2; wt_v[1] = 2; fq_v[1] = 1000;
    clear_rt();
    for (int i = 0; i < 3; i++) begin
      fq_v[0] = $urandom_range(0, 1023);
      run_frame();
    end
    // Busy, during ch0's slot, before ch1's slot.
    rt_c[1] = 2'b10;
    run_frame();
    clear_rt();
    n_run++; if (obs_d[1] !== 0) begin n_fail++; $display("FAIL retrig_busy_d_out got %0d want 0", obs_d[1]); end
    n_run++; if (obs_wv[3] !== 2'b00) begin n_fail++; $display("FAIL retrig_busy_wrap got %b want 00", obs_wv[3]); end
    n_run++; if (obs_d[0] !== exp_d[0]) begin n_fail++; $display("FAIL retrig_ch0_unaffected got %0d want %0d", obs_d[0], exp_d[0]); end
    run_frame();
    n_run++; if (obs_d[1] !== 250) begin n_fail++; $display("FAIL retrig_resume got %0d want 250", obs_d[1]); end
    // Idle retrig.
    idle_retrig(2'b10);
    run_frame();
    n_run++; if (obs_d[1] !== 0) begin n_fail++; $display("FAIL retrig_idle_d_out got %0d want 0", obs_d[1]); end
    n_run++; if (obs_wv[3] !== 2'b00) begin n_fail++; $display("FAIL retrig_idle_wrap got %b want 00", obs_wv[3]); end
    n_run++; if (obs_d[0] !== exp_d[0]) begin n_fail++; $display("FAIL retrig_idle_ch0 got %0d want %0d", obs_d[0], exp_d[0]); end
    // Retrig in ch1's own slot takes effect immediately and leaves nothing pending.
    run_frame();
    rt_c[2] = 2'b10;
    run_frame();
    clear_rt();
    n_run++; if (obs_d[1] !== 0) begin n_fail++; $display("FAIL retrig_slot got %0d want 0", obs_d[1]); end
    run_frame();
    n_run++; if (obs_d[1] !== 250) begin n_fail++; $display("FAIL retrig_slot_nopend got %0d want 250", obs_d[1]); end
    // Random mode latches a fresh LFSR value on retrig.
    wt_v[1] = 4; fq_v[1] = 1;
    idle_retrig(2'b10);
    run_frame();
    n_run++; if (obs_d[1] !== ((lfsr_m >> 6) & 1023)) begin n_fail++; $display("FAIL retrig_random got %0d want %0d", obs_d[1], (lfsr_m >> 6) & 1023); end
  endtask

  task automatic test_back_to_back();
    int dv_cnt;
    se_extra = 1'b1;
    fq_v[0] = $urandom_range(0, 1023); fq_v[1] = $urandom_range(0, 1023);
    run_frame();
    se_extra = 1'b0;
    dv_cnt = 0;
    for (int c = 0; c < 6; c++) dv_cnt += int'(obs_dv[c]);
    n_run++; if (dv_cnt !== 1 || obs_dv[4] !== 1'b1) begin n_fail++; $display("FAIL extra_se_d_valid got count %0d want 1", dv_cnt); end
    n_run++; if (obs_d[0] !== exp_d[0] || obs_d[1] !== exp_d[1]) begin n_fail++; $display("FAIL extra_se_d_out got %0d/%0d want %0d/%0d", obs_d[0], obs_d[1], exp_d[0], exp_d[1]); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_run++; if (busy !== 1'b0 || d_valid !== 1'b0) begin n_fail++; $display("FAIL extra_se_idle got busy=%b d_valid=%b want 0/0", busy, d_valid); end
    end
    // Randomized frames across all wave codes with sparse retrigs.
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < 2; k++) begin
        wt_v[k] = $urandom_range(0, 7);
        fq_v[k] = $urandom_range(0, 1023);
        pw_v[k] = $urandom_range(0, 1023);
      end
      for (int c = 0; c < 5; c++) rt_c[c] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      run_frame();
      for (int k = 0; k < 2; k++) begin
        n_run++; if (obs_d[k] !== exp_d[k]) begin n_fail++; $display("FAIL random_ch%0d got %0d want %0d", k, obs_d[k], exp_d[k]); end
      end
      n_run++; if (obs_wv[2] !== {1'b0, 1'(exp_w[0])} || obs_wv[3] !== {1'(exp_w[1]), 1'b0}) begin n_fail++; $display("FAIL random_wrap got %b/%b want %0d/%0d", obs_wv[2], obs_wv[3], exp_w[0], exp_w[1]); end
    end
    clear_rt();
  endtask

  task automatic test_reset_mid();
    int dv_seen;
    wt_v[0] = 4; wt_v[1] = 4; fq_v[0] = 3; fq_v[1] = 5;
    @(negedge clk);
    apply_cfg();
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_run++; if (d_out !== '0 || wrap !== 2'b00) begin n_fail++; $display("FAIL midreset_outputs got %0h/%b want 0/00", d_out, wrap); end
    n_run++; if (busy !== 1'b0 || d_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_status got busy=%b d_valid=%b want 0/0", busy, d_valid); end
    reset_n = 1'b1;
    model_reset();
    dv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dv_seen += int'(d_valid);
    end
    n_run++; if (dv_seen !== 0) begin n_fail++; $display("FAIL midreset_no_d_valid got %0d want 0", dv_seen); end
    // First frame after reset: LFSR starts from ACE1, shifted once -> 59C3.
    idle_retrig(2'b11);
    run_frame();
    n_run++; if (obs_d[0] !== 359 || obs_d[1] !== 359) begin n_fail++; $display("FAIL lfsr_seed got %0d/%0d want 359/359", obs_d[0], obs_d[1]); end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      wt_v[k] = 0; fq_v[k] = 0; pw_v[k] = 0;
    end
    clear_rt();
    model_reset();
    test_reset();
    test_saw();
    test_square();
    test_tri_sine();
    test_retrig();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
